layer_mac_sequencer: RTL

Time-multiplexed neuron engine for one fully-connected layer. One shared 8x8 signed multiplier and 23-bit accumulator evaluate N_OUT neurons in turn, each with N_IN inputs. It reads activations, weights and biases from external synchronous memories and emits one quantised ReLU byte per neuron over a valid/ready handshake. It replaces per-node parallel MAC instances when area matters more than latency; its outputs are bit-exact with the parallel node arithmetic.

---
 rtl/layer_mac_sequencer.sv | 117 +++++++++++
 1 files changed

// File: rtl/layer_mac_sequencer.sv
// Time-multiplexed fully-connected layer: one shared 8x8 MAC walks N_OUT neurons of N_IN inputs,
// reading external synchronous memories and emitting one quantised ReLU byte per neuron.
module layer_mac_sequencer #(
  parameter int N_IN  = 15,
  parameter int N_OUT = 32,
  parameter int IA_W  = 4,
  parameter int WA_W  = 9,
  parameter int NA_W  = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [IA_W-1:0] in_addr,
  input  logic [7:0]      in_data,
  output logic [WA_W-1:0] w_addr,
  input  logic [7:0]      w_data,
  output logic [NA_W-1:0] b_addr,
  input  logic [15:0]     b_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [NA_W-1:0] out_idx,
  output logic [7:0]      out_data
);

  typedef enum logic [2:0] {IDLE, FETCH, MAC, ACT, DONE} state_t;

  state_t            state, state_nxt;
  logic [NA_W-1:0]   n;
  logic [IA_W-1:0]   j;
  logic [22:0]       acc;
  logic signed [15:0] prod;
  logic              last_j, last_n, addr_last;

  assign prod      = $signed(in_data) * $signed(w_data);
  assign last_j    = (j == IA_W'(N_IN - 1));
  assign last_n    = (n == NA_W'(N_OUT - 1));
  assign addr_last = (in_addr == IA_W'(N_IN - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   state_nxt = MAC;
      MAC:     if (last_j) state_nxt = ACT;
      ACT:     if (out_ready) state_nxt = last_n ? DONE : FETCH;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Addresses are registered, so each one is loaded on the edge entering the cycle that
  // presents it: FETCH shows address 0, MAC step j shows j+1, and the last address holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      n       <= '0;
      j       <= '0;
      acc     <= '0;
      in_addr <= '0;
      w_addr  <= '0;
      b_addr  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          n       <= '0;
          in_addr <= '0;
          w_addr  <= '0;
          b_addr  <= '0;
        end
        FETCH: begin
          j <= '0;
          if (!addr_last) begin
            in_addr <= in_addr + 1'b1;
            w_addr  <= w_addr + 1'b1;
          end
        end
        MAC: begin
          if (j == '0) acc <= {{7{b_data[15]}}, b_data} + {{7{prod[15]}}, prod};
          else         acc <= acc + {{7{prod[15]}}, prod};
          j <= j + 1'b1;
          if (!addr_last) begin
            in_addr <= in_addr + 1'b1;
            w_addr  <= w_addr + 1'b1;
          end
        end
        // Next neuron's weight base is one past this neuron's held last address.
        ACT: if (out_ready && !last_n) begin
          n       <= n + 1'b1;
          b_addr  <= n + 1'b1;
          in_addr <= '0;
          w_addr  <= w_addr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Exact halves round down; round-up from 127 wraps to 8'h80 to match the parallel nodes.
  always_comb begin
    out_data = acc[13:6];
    if (acc[22])                    out_data = '0;
    else if (|acc[21:13])           out_data = 8'd127;
    else if (acc[5] && |acc[4:0])   out_data = acc[13:6] + 8'd1;
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign out_valid = (state == ACT);
  assign out_idx   = n;

endmodule
